// File: rtl/tpm_host_sequencer.sv
// rtl/tpm_host_sequencer.sv - TPM FIFO-interface host sequencer; optional poll timeout via TPM_SEQ_POLL_TIMEOUT_EN
module tpm_host_sequencer #(
  parameter int MAX_LEN    = 4096,
  parameter int POLL_LIMIT = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  cmdData,
  input  logic        cmdValid,
  output logic        cmdReady,
  output logic [7:0]  rspData,
  output logic        rspValid,
  input  logic        rspReady,
  output logic [15:0] hostAddr,
  output logic [7:0]  hostInData,
  input  logic [7:0]  hostOutData,
  output logic        hostIsWrite,
  output logic        hostStart,
  input  logic        hostIsReady,
  input  logic        hostGotResponse,
  output logic        busy,
  output logic        done,
  output logic        error
);
  localparam logic [15:0] ADDR_ACCESS = 16'h0000;
  localparam logic [15:0] ADDR_STS    = 16'h0018;
  localparam logic [15:0] ADDR_FIFO   = 16'h0024;

  typedef enum logic [3:0] {
    S_IDLE, S_REQ_LOC, S_CMD_READY, S_SEND, S_GO,
    S_POLL, S_RECV, S_RELEASE, S_RELINQUISH
  } state_t;

  state_t      r_state, w_next;
  logic        r_req, r_pend, r_seen_low, r_seen_resp;
  logic [7:0]  r_rd_data;
  logic [31:0] r_cnt, r_len;
  logic        w_start, w_acc_done, w_cmd_fire, w_rsp_fire;
  logic        w_len_bad, w_len_byte, w_abort, w_poll_expired;
  logic [7:0]  w_rd_data;
  logic        w_issue, w_wr;
  logic [15:0] w_addr;
  logic [7:0]  w_wdata;

  // A request waits in r_req until the host port is idle, so hostStart never fires while it is busy.
  assign w_start    = r_req & hostIsReady;
  assign hostStart  = w_start;
  assign w_acc_done = r_pend & r_seen_low & hostIsReady & (hostIsWrite | r_seen_resp | hostGotResponse);
  assign w_rd_data  = hostGotResponse ? hostOutData : r_rd_data;
  assign cmdReady   = (r_state == S_SEND) & ~r_req & ~r_pend;
  assign w_cmd_fire = cmdValid & cmdReady;
  assign w_rsp_fire = rspValid & rspReady;
  assign w_len_bad  = (r_len < 32'd10) || (r_len > 32'(MAX_LEN));
  assign w_len_byte = (r_cnt >= 32'd2) && (r_cnt <= 32'd5);

`ifdef TPM_SEQ_POLL_TIMEOUT_EN
  logic [31:0] r_poll_cnt;
  assign w_poll_expired = (r_poll_cnt >= 32'(POLL_LIMIT));

  // Count STS reads issued since entering POLL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 r_poll_cnt <= '0;
    else if (r_state != S_POLL) r_poll_cnt <= '0;
    else if (w_start)          r_poll_cnt <= r_poll_cnt + 32'd1;
  end
`else
  logic w_unused_poll_limit;
  assign w_poll_expired      = 1'b0;
  assign w_unused_poll_limit = ^32'(POLL_LIMIT);
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode; length checks happen once header bytes 2..5 are in.
  always_comb begin
    w_next  = r_state;
    w_abort = 1'b0;
    case (r_state)
      S_IDLE:      if (cmdValid) w_next = S_REQ_LOC;
      S_REQ_LOC:   if (w_acc_done) w_next = S_CMD_READY;
      S_CMD_READY: if (w_acc_done) w_next = S_SEND;
      S_SEND: if (w_acc_done) begin
        if (r_cnt == 32'd6 && w_len_bad) begin
          w_abort = 1'b1;
          w_next  = S_RELEASE;
        end else if (r_cnt >= 32'd6 && r_cnt == r_len) begin
          w_next = S_GO;
        end
      end
      S_GO:        if (w_acc_done) w_next = S_POLL;
      S_POLL: if (w_acc_done) begin
        if ((w_rd_data & 8'h90) == 8'h90) begin
          w_next = S_RECV;
        end else if (w_poll_expired) begin
          w_abort = 1'b1;
          w_next  = S_RELEASE;
        end
      end
      S_RECV: if (w_rsp_fire) begin
        if (r_cnt == 32'd5 && w_len_bad) begin
          w_abort = 1'b1;
          w_next  = S_RELEASE;
        end else if (r_cnt >= 32'd5 && (r_cnt + 32'd1) == r_len) begin
          w_next = S_RELEASE;
        end
      end
      S_RELEASE:    if (w_acc_done) w_next = S_RELINQUISH;
      S_RELINQUISH: if (w_acc_done) w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  // Host access to queue: one on state entry, or a repeat within SEND/POLL/RECV.
  always_comb begin
    w_issue = 1'b0;
    w_wr    = 1'b0;
    w_addr  = ADDR_ACCESS;
    w_wdata = 8'h00;
    if (w_next != r_state) begin
      case (w_next)
        S_REQ_LOC:    begin w_issue = 1'b1; w_wr = 1'b1; w_addr = ADDR_ACCESS; w_wdata = 8'h02; end
        S_CMD_READY:  begin w_issue = 1'b1; w_wr = 1'b1; w_addr = ADDR_STS;    w_wdata = 8'h40; end
        S_GO:         begin w_issue = 1'b1; w_wr = 1'b1; w_addr = ADDR_STS;    w_wdata = 8'h20; end
        S_POLL:       begin w_issue = 1'b1; w_addr = ADDR_STS;  end
        S_RECV:       begin w_issue = 1'b1; w_addr = ADDR_FIFO; end
        S_RELEASE:    begin w_issue = 1'b1; w_wr = 1'b1; w_addr = ADDR_STS;    w_wdata = 8'h40; end
        S_RELINQUISH: begin w_issue = 1'b1; w_wr = 1'b1; w_addr = ADDR_ACCESS; w_wdata = 8'h20; end
        default:      w_issue = 1'b0;
      endcase
    end else if (r_state == S_SEND && w_cmd_fire) begin
      w_issue = 1'b1; w_wr = 1'b1; w_addr = ADDR_FIFO; w_wdata = cmdData;
    end else if (r_state == S_POLL && w_acc_done) begin
      w_issue = 1'b1; w_addr = ADDR_STS;
    end else if (r_state == S_RECV && w_rsp_fire) begin
      w_issue = 1'b1; w_addr = ADDR_FIFO;
    end
  end

  // Host handshake: hold request fields, then track ready-low and response until completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req       <= 1'b0;
      r_pend      <= 1'b0;
      r_seen_low  <= 1'b0;
      r_seen_resp <= 1'b0;
      r_rd_data   <= 8'h00;
      hostAddr    <= 16'h0000;
      hostInData  <= 8'h00;
      hostIsWrite <= 1'b0;
    end else begin
      if (w_issue) begin
        r_req       <= 1'b1;
        hostAddr    <= w_addr;
        hostInData  <= w_wdata;
        hostIsWrite <= w_wr;
      end else if (w_start) begin
        r_req <= 1'b0;
      end
      if (w_start) begin
        r_pend      <= 1'b1;
        r_seen_low  <= 1'b0;
        r_seen_resp <= 1'b0;
      end else if (w_acc_done) begin
        r_pend <= 1'b0;
      end else if (r_pend) begin
        if (!hostIsReady)    r_seen_low  <= 1'b1;
        if (hostGotResponse) r_seen_resp <= 1'b1;
      end
      if (r_pend && hostGotResponse) r_rd_data <= hostOutData;
    end
  end

  // Byte counting, header length capture, response presentation and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_len    <= '0;
      rspData  <= 8'h00;
      rspValid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      if (w_next != r_state && (w_next == S_SEND || w_next == S_RECV)) begin
        r_cnt <= '0;
        r_len <= '0;
      end else if (r_state == S_SEND && w_cmd_fire) begin
        r_cnt <= r_cnt + 32'd1;
        if (w_len_byte) r_len <= {r_len[23:0], cmdData};
      end else if (r_state == S_RECV) begin
        if (w_acc_done && w_len_byte) r_len <= {r_len[23:0], w_rd_data};
        if (w_rsp_fire) r_cnt <= r_cnt + 32'd1;
      end
      if (r_state == S_RECV && w_acc_done) begin
        rspData  <= w_rd_data;
        rspValid <= 1'b1;
      end else if (w_rsp_fire) begin
        rspValid <= 1'b0;
      end
      busy <= (w_next != S_IDLE);
      done <= (r_state == S_RELINQUISH) && (w_next == S_IDLE) && !error;
      if (r_state == S_IDLE && w_next != S_IDLE) error <= 1'b0;
      else if (w_abort)                          error <= 1'b1;
    end
  end
endmodule

// File: doc/tpm_host_sequencer.md
# tpm_host_sequencer

Drives one complete TPM FIFO-interface transaction on the host-side register port of the TPM manager. It accepts a command byte stream, requests locality 0, and writes the command to the data FIFO. It then issues tpmGo, polls status until the response is ready, and streams the response bytes out before releasing the TPM. It sits between the command source (UART/bypass logic) and the host register port that talks to the physical TPM.

## Interface
Parameters:
- MAX_LEN, 4096: largest legal command/response size in bytes; header sizes above this are errors.
- POLL_LIMIT, 100000: number of status reads before the poll loop times out. Used only with the macro in Configuration.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmdData  in  8  command byte
- cmdValid  in  1  cmdData valid
- cmdReady  out  1  command byte accepted when cmdValid && cmdReady
- rspData  out  8  response byte
- rspValid  out  1  rspData valid; held until accepted
- rspReady  in  1  consumer accepts rspData
- hostAddr  out  16  TPM register address
- hostInData  out  8  write data to the TPM
- hostOutData  in  8  read data from the TPM
- hostIsWrite  out  1  1 = write, 0 = read
- hostStart  out  1  one-cycle transaction start pulse
- hostIsReady  in  1  host port idle
- hostGotResponse  in  1  one-cycle pulse; hostOutData valid
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at return to IDLE after success
- error  out  1  sticky; set on abort, cleared when the next sequence starts

## Operation
- Registers used: ACCESS = 0x0000, STS = 0x0018, DATA_FIFO = 0x0024.
- States and the host access each one performs:
  - IDLE
  - REQ_LOC: write ACCESS = 0x02
  - CMD_READY: write STS = 0x40
  - SEND: write DATA_FIFO = each command byte
  - GO: write STS = 0x20
  - POLL: read STS
  - RECV: read DATA_FIFO
  - RELEASE: write STS = 0x40
  - RELINQUISH: write ACCESS = 0x20
- IDLE → REQ_LOC when cmdValid = 1. The byte is not consumed in IDLE. This transition clears error and sets busy.
- REQ_LOC → CMD_READY → SEND, each after its write completes.
- SEND:
  - cmdReady = 1 only when in SEND with no host transaction outstanding.
  - Each accepted byte is issued as a DATA_FIFO write.
  - Command bytes 2..5 form a big-endian 32-bit length.
  - After byte 5, a length < 10 or > MAX_LEN aborts.
  - SEND → GO after the write of byte number length-1 (0-based) completes.
- GO → POLL.
- POLL: reissues STS reads back-to-back. Goes to RECV when (sts & 0x90) == 0x90 (stsValid | dataAvail). Any other value repeats the read.
- RECV:
  - Each read byte is presented on rspData/rspValid.
  - The next read is not issued until the current byte is accepted.
  - Response bytes 2..5 form the response length, with the same legality check as commands.
  - RECV → RELEASE after byte length-1 is accepted.
- RELEASE → RELINQUISH → IDLE. At that transition: done pulses, busy drops.
- Abort: sets error, stops accepting or reading bytes, and goes directly to RELEASE. cmdValid bytes remaining from an aborted command are not consumed by this block.
- Counters: byte counter is 32 bits, compared against the 32-bit length.

## Timing
- Reset values: hostStart = 0, hostIsWrite = 0, hostAddr = 0, hostInData = 0, cmdReady = 0, rspValid = 0, rspData = 0, busy = 0, done = 0, error = 0. State = IDLE.
- Reset mid-sequence returns to IDLE immediately. The TPM is left as-is; no RELEASE is issued.
- hostStart:
  - Asserted only in a cycle where hostIsReady = 1.
  - Registered: first possible pulse is the cycle after state entry.
  - hostAddr, hostInData and hostIsWrite are valid with hostStart and held stable until the transaction completes.
- Transaction complete: hostIsReady has been seen 0 after hostStart and is 1 again. For reads, hostGotResponse has also been seen; hostOutData is captured in the hostGotResponse cycle.
- Next hostStart: no earlier than the cycle after completion.
- Command byte: cmdReady drops the cycle after acceptance; the FIFO write starts the following cycle.
- Response byte: rspValid rises the cycle after capture and falls the cycle after the rspReady handshake.

## Configuration
- TPM_SEQ_POLL_TIMEOUT_EN defined:
  - POLL counts issued STS reads.
  - When POLL_LIMIT reads complete without a ready status, the block aborts (error = 1, → RELEASE).
- Undefined: no counter; POLL continues indefinitely.

## Test plan
- Nominal GetRandom:
  - Command stream 80 01 00 00 00 0c 00 00 01 7b 00 08.
  - Model returns STS 0x04 ×30, then 0x94, then 20 response bytes 80 01 00 00 00 14 00 00 00 00 00 08 06 3c 31 f1 2a 64 e6 e8.
  - Required host access order: ACCESS = 02, STS = 40, 12 FIFO writes in order, STS = 20, 31 STS reads, 20 FIFO reads, STS = 40, ACCESS = 20.
  - rspData matches the 20 bytes; done pulses once; error = 0.
- Backpressure: hold rspReady = 0 for 40 cycles at byte 7 → no DATA_FIFO read issued during the stall; byte order is intact.
- Bad length: command header length 0x00000005 → error = 1 after byte 5; then STS = 40 and ACCESS = 20; cmdReady stays 0.
- Slow host: hostIsReady held low 20 cycles per access → exactly one hostStart per access; no overlap.
- Reset asserted during POLL → all outputs at reset values the same cycle. A following nominal command completes correctly.
- With TPM_SEQ_POLL_TIMEOUT_EN and POLL_LIMIT = 8, STS always 0x04 → exactly 8 STS reads, error = 1, then the release writes; done does not pulse.
